// File: rtl/branch_ctrl_seq.sv
// Conditional-branch control-step sequencer: fetch T0-T2, branch execute T3-T6.
// Moore control outputs (MDRins additionally qualified by mem_ready in T1).
// Optional feature macro: BR_MEM_TIMEOUT_EN enables a T1 memory-wait timeout and sticky err.
module branch_ctrl_seq #(
    parameter logic [4:0]  BR_OPCODE   = 5'b11011,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] bus_in,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MARins,
    output logic        incPC,
    output logic        MDRRead,
    output logic        MDRins,
    output logic        MDRout,
    output logic        IRins,
    output logic [15:0] Rout,
    output logic        Yins,
    output logic        Cout,
    output logic        ZLOins,
    output logic        ZLOout,
    output logic        PCins,
    output logic        alu_add,
    output logic        con,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        err
);

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StDone
    } state_t;

    state_t r_state;
    logic   r_con;
    logic   r_illegal;
    logic   r_err;
    logic   w_is_branch;
    logic   w_cond;
    logic   w_unused_ir;

    assign w_is_branch = (ir[31:27] == BR_OPCODE);
    // Only opcode, Ra and C2 are decoded here; C is consumed by the datapath.
    assign w_unused_ir = ^{ir[22:21], ir[18:0]};

`ifdef BR_MEM_TIMEOUT_EN
    logic [3:0] r_wait;
    logic       w_timeout;
    assign w_timeout = !mem_ready && (r_wait == 4'(MEM_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |MEM_TIMEOUT;
`endif

    // Branch condition from C2 = ir[20:19] against the current bus value.
    always_comb begin
        w_cond = 1'b0;
        unique case (ir[20:19])
            2'b00: w_cond = (bus_in == 32'd0);
            2'b01: w_cond = (bus_in != 32'd0);
            2'b10: w_cond = !bus_in[31];
            2'b11: w_cond = bus_in[31];
            default: w_cond = 1'b0;
        endcase
    end

    // State sequencing plus the con/illegal/err flags; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= StIdle;
            r_con     <= 1'b0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
`ifdef BR_MEM_TIMEOUT_EN
            r_wait    <= 4'd0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state   <= StT0;
                        r_illegal <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                StT0: begin
                    r_state <= StT1;
`ifdef BR_MEM_TIMEOUT_EN
                    r_wait  <= 4'd0;
`endif
                end
                StT1: begin
                    if (mem_ready) begin
                        r_state <= StT2;
                    end
`ifdef BR_MEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_wait  <= r_wait + 4'd1;
                    end
`endif
                end
                // Opcode is checked on the edge that loads IR so a bad fetch skips execute.
                StT2: begin
                    if (w_is_branch) begin
                        r_state <= StT3;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= StDone;
                    end
                end
                StT3: begin
                    r_con   <= w_cond;
                    r_state <= StT4;
                end
                StT4:    r_state <= StT5;
                StT5:    r_state <= StT6;
                StT6:    r_state <= StDone;
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Control decode from the registered state; one bus driver per state at most.
    always_comb begin
        PCout   = 1'b0;
        MARins  = 1'b0;
        incPC   = 1'b0;
        MDRRead = 1'b0;
        MDRins  = 1'b0;
        MDRout  = 1'b0;
        IRins   = 1'b0;
        Rout    = 16'd0;
        Yins    = 1'b0;
        Cout    = 1'b0;
        ZLOins  = 1'b0;
        ZLOout  = 1'b0;
        PCins   = 1'b0;
        alu_add = 1'b0;
        done    = 1'b0;
        unique case (r_state)
            StT0: begin
                PCout  = 1'b1;
                MARins = 1'b1;
                incPC  = 1'b1;
            end
            StT1: begin
                MDRRead = 1'b1;
                MDRins  = mem_ready;
            end
            StT2: begin
                MDRout = 1'b1;
                IRins  = 1'b1;
            end
            StT3: Rout = 16'd1 << ir[26:23];
            StT4: begin
                PCout = 1'b1;
                Yins  = 1'b1;
            end
            StT5: begin
                Cout    = 1'b1;
                alu_add = 1'b1;
                ZLOins  = 1'b1;
            end
            StT6: begin
                ZLOout = 1'b1;
                PCins  = r_con;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (r_state != StIdle);
    assign con     = r_con;
    assign illegal = r_illegal;
    assign err     = r_err;

endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Scoreboarded bench for branch_ctrl_seq: expected per-instruction results are queued
// when an instruction is launched and compared when the done pulse is observed.
module tb_branch_ctrl_seq;

`ifdef BR_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr, start, mem_ready;
    logic [31:0] ir, bus_in;
    logic        PCout, MARins, incPC, MDRRead, MDRins, MDRout, IRins;
    logic [15:0] Rout;
    logic        Yins, Cout, ZLOins, ZLOout, PCins, alu_add, con, busy, done, illegal, err;

    branch_ctrl_seq dut (
        .clk(clk), .clr(clr), .start(start), .ir(ir), .bus_in(bus_in), .mem_ready(mem_ready),
        .PCout(PCout), .MARins(MARins), .incPC(incPC), .MDRRead(MDRRead), .MDRins(MDRins),
        .MDRout(MDRout), .IRins(IRins), .Rout(Rout), .Yins(Yins), .Cout(Cout), .ZLOins(ZLOins),
        .ZLOout(ZLOout), .PCins(PCins), .alu_add(alu_add), .con(con), .busy(busy), .done(done),
        .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int con;
        int illegal;
        int err;
        int lat;
        int rd;
        int ins;
        int fetch;
        int exec;
        int pcins;
        int rout;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   conflicts = 0;
    int   model_con = 0;

    logic [17:0] w_ctrl;
    assign w_ctrl = {PCout, MARins, incPC, MDRRead, MDRins, MDRout, IRins, Yins, Cout, ZLOins,
                     ZLOout, PCins, alu_add, con, busy, done, illegal, err};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Per-instruction activity counters, sampled on the falling edge.
    int m_lat, m_rd, m_ins, m_fetch, m_exec, m_pcins, m_rout;
    always @(negedge clk) begin
        if (busy) begin
            m_lat++;
            m_rd    += int'(MDRRead);
            m_ins   += int'(MDRins);
            m_fetch += int'(PCout) + int'(MARins) + int'(incPC) + int'(MDRout) + int'(IRins);
            m_exec  += int'(Yins) + int'(Cout) + int'(ZLOins) + int'(ZLOout) + int'(alu_add);
            m_pcins += int'(PCins);
            if (Rout != 16'd0) m_rout = int'(Rout);
            if (int'(PCout) + int'(MDRout) + int'(Cout) + int'(ZLOout) + $countones(Rout) > 1)
                conflicts++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("latency", m_lat, e.lat);
                    check_eq("con", 32'(con), e.con);
                    check_eq("illegal", 32'(illegal), e.illegal);
                    check_eq("err", 32'(err), e.err);
                    check_eq("mdrread_cycles", m_rd, e.rd);
                    check_eq("mdrins_cycles", m_ins, e.ins);
                    check_eq("fetch_ctrls", m_fetch, e.fetch);
                    check_eq("exec_ctrls", m_exec, e.exec);
                    check_eq("pcins_cycles", m_pcins, e.pcins);
                    check_eq("rout", m_rout, e.rout);
                end
                done_cnt++;
            end
        end else begin
            m_lat = 0; m_rd = 0; m_ins = 0; m_fetch = 0; m_exec = 0; m_pcins = 0; m_rout = 0;
        end
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [1:0] c2);
        return {op, ra, 2'b00, c2, 19'h001FF};
    endfunction

    function automatic int model_cond(input logic [1:0] c2, input logic [31:0] b);
        case (c2)
            2'b00:   return (b == 32'd0) ? 1 : 0;
            2'b01:   return (b != 32'd0) ? 1 : 0;
            2'b10:   return b[31] ? 0 : 1;
            default: return b[31] ? 1 : 0;
        endcase
    endfunction

    task automatic run_txn(input logic [31:0] t_ir, input logic [31:0] t_bus, input int waits);
        exp_t e;
        int   n0;
        int   c;
        bit   legal;
        bit   tmo;
        legal = (t_ir[31:27] == 5'b11011);
        tmo   = TO_EN && (waits >= 15);
        c     = model_cond(t_ir[20:19], t_bus);
        if (tmo) begin
            e = '{con: model_con, illegal: 0, err: 1, lat: 17, rd: 15, ins: 0, fetch: 3,
                  exec: 0, pcins: 0, rout: 0};
        end else if (!legal) begin
            e = '{con: model_con, illegal: 1, err: 0, lat: 4 + waits, rd: waits + 1, ins: 1,
                  fetch: 5, exec: 0, pcins: 0, rout: 0};
        end else begin
            e = '{con: c, illegal: 0, err: 0, lat: 8 + waits, rd: waits + 1, ins: 1, fetch: 6,
                  exec: 5, pcins: c, rout: 1 << t_ir[26:23]};
            model_con = c;
        end
        exp_q.push_back(e);
        ir        = t_ir;
        bus_in    = t_bus;
        mem_ready = (waits == 0);
        n0        = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);  // T0: start still high, must not restart
        @(negedge clk);
        start = 1'b0;
        repeat (waits) @(negedge clk);
        mem_ready = 1'b1;
        for (int i = 0; i < 60 && done_cnt == n0; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == n0) check_eq("done_wait_expired", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_illegal", 32'(illegal), e.illegal);
        check_eq("idle_err", 32'(err), e.err);
        check_eq("idle_con", 32'(con), e.con);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = 32'd0; bus_in = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", 32'(w_ctrl), 32'd0);
        check_eq("reset_rout", 32'(Rout), 32'd0);
        clr = 1'b0;

        run_txn(32'hD80001FF, 32'd0, 0);                           // zero taken
        run_txn(32'hD80001FF, 32'h22, 0);                          // zero not taken
        run_txn(mk_ir(5'b11011, 4'd3, 2'b10), 32'h8000_0000, 0);   // plus, negative
        run_txn(mk_ir(5'b11011, 4'd5, 2'b11), 32'h8000_0000, 0);   // minus, negative
        run_txn(mk_ir(5'b11011, 4'd15, 2'b01), 32'h22, 0);         // nonzero
        run_txn(32'hC00001FF, 32'd0, 0);                           // illegal opcode
        run_txn(mk_ir(5'b11011, 4'd9, 2'b10), 32'h7FFF_FFFF, 3);   // three memory waits

        // clr in T4 aborts immediately
        ir = 32'hD80001FF; bus_in = 32'd0; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !Yins; i++) @(negedge clk);
        check_eq("abort_reached_t4", 32'(Yins), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        check_eq("abort_ctrl", 32'(w_ctrl), 32'd0);
        check_eq("abort_rout", 32'(Rout), 32'd0);
        clr = 1'b0;
        model_con = 0;

        run_txn(mk_ir(5'b11011, 4'd1, 2'b00), 32'd0, 20);          // long wait or timeout
        run_txn(32'hD80001FF, 32'd0, 0);                           // clears sticky flags

        check_eq("bus_conflicts", conflicts, 32'd0);
        check_eq("sb_leftover", exp_q.size(), 32'd0);
        check_eq("done_count", done_cnt, 32'd9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
